fft_frame_tx: RTL and testbench
===============================

// Module: fft_frame_tx
// PURPOSE
//  - Frame transmitter feeding the FFT core's input stream (i_data_valid/i_data/o_data_ready side of top).
//  - Host/loader writes one N-sample frame into a local buffer, then pulses start.
//  - Block streams the frame out over valid/ready, in natural or bit-reversed index order.
//  - Marks the last beat and pulses done; sits between the sample loader and the FFT core input.
// PARAMETERS
//  - N_LOG2   8   log2 of frame length; N = 2**N_LOG2 samples (256)
//  - DATA_W   32  sample width, packed {re[15:0], im[15:0]}; passed through uninterpreted
// PORTS
//  - i_clk         in   1       single clock, all logic on rising edge
//  - i_rst         in   1       reset, synchronous, active-high
//  - i_wr_en       in   1       buffer write strobe
//  - i_wr_addr     in   N_LOG2  buffer write index
//  - i_wr_data     in   DATA_W  buffer write sample
//  - i_start       in   1       1-cycle pulse: transmit buffered frame
//  - i_bitrev      in   1       sampled with accepted start: 1 = send in bit-reversed index order
//  - o_busy        out  1       high from accepted start until last beat accepted
//  - o_data_valid  out  1       output beat valid
//  - o_data        out  DATA_W  output sample
//  - o_data_last   out  1       high with the beat for sequence index N-1
//  - i_data_ready  in   1       downstream (FFT core) accepts beat when valid & ready
//  - o_frame_done  out  1       1-cycle pulse, cycle after last beat accepted
//  - o_err         out  1       1-cycle pulse: start or write rejected while busy
// BEHAVIOUR
//  - Reset: o_busy, o_data_valid, o_data_last, o_frame_done, o_err = 0; o_data = 0; state IDLE.
//  - Reset takes effect the cycle after i_rst is sampled high, including mid-frame; the frame is dropped.
//  - Buffer contents are not reset.
//  - Buffer: N x DATA_W, synchronous write, 1-cycle registered read.
//  - Writes are accepted only in IDLE.
//  - A write while o_busy is dropped and pulses o_err.
//  - FSM IDLE -> FETCH -> SEND -> DONE -> IDLE.
//    - IDLE: i_start accepted; latch i_bitrev; seq counter k = 0; o_busy = 1 next cycle.
//    - FETCH: one cycle; RAM read of index(0) issued.
//    - SEND: o_data_valid = 1.
//      - On handshake with k < N-1: k++ and present index(k+1) on the next cycle.
//      - On handshake with k = N-1: go to DONE.
//    - DONE: one cycle; o_frame_done = 1; o_busy = 0; o_data_valid = 0.
//  - index(k) = k when bitrev = 0; otherwise k with its N_LOG2 bits reversed.
//  - Latency: start at cycle t -> first o_data_valid at t+2.
//  - Throughput: 1 beat/cycle while i_data_ready is held high; N beats in N cycles.
//  - Stall: while valid & !ready, o_data and o_data_last are held stable; no beat is skipped or repeated.
//    - RAM is read-ahead with a 1-entry holding register, or the read address is held.
//  - Valid is never withdrawn without a handshake, except by reset.
//  - A start asserted in the same cycle as the DONE pulse is rejected with o_err.
//  - A new start is accepted the cycle after DONE.
//  - Simultaneous i_start and i_wr_en in IDLE: the write lands first.
//    - The written sample is visible to the frame, because the read occurs at FETCH or later.
//  - k is N_LOG2 bits wide; it never wraps in SEND because the last beat exits to DONE.
// STRUCTURE
//  - Shared include fft_defs.vh holds:
//    - FFT_N_LOG2 / FFT_DATA_W defaults
//    - state encodings IDLE=2'd0, FETCH=2'd1, SEND=2'd2, DONE=2'd3
//    - a bit-reverse function
//  - One sub-module: fft_frame_ram (simple dual-port, 1 write / 1 read port, registered read, inferable BRAM).
//  - FSM, sequence counter, index mapping and output register live in fft_frame_tx.
// TESTING
//  1. Write 0x00010000*i for i = 0..255; start with bitrev=0, ready held high.
//     -> 256 beats on consecutive cycles with o_data = 0x00010000*k.
//     -> last high only on the 0x00FF0000 beat; done one cycle later.
//  2. Same frame, start with bitrev=1.
//     -> beat sequence 0x00000000, 0x00800000, 0x00400000, 0x00C00000, ...; last on 0x00FF0000.
//  3. Ready toggled with pseudo-random 50% duty.
//     -> data stable while stalled; exactly 256 handshakes, in order; no duplicates.
//  4. Start and write pulsed during beat 10.
//     -> two o_err pulses; the frame is unaffected; buffer entry unchanged after done.
//  5. i_rst asserted at beat 100 for one cycle.
//     -> all outputs 0 the next cycle; a fresh start sends from beat 0 with the buffer intact.
//  6. Start is sampled at cycle t.
//     -> o_data_valid first high at t+2; o_busy high from t+1 until the DONE cycle.

Source files
------------

// File: rtl/fft_frame_tx_pkg.sv
// Shared definitions for the FFT frame transmitter: default sizes,
// FSM state encoding and the index bit-reversal helper.
package fft_frame_tx_pkg;

  // Default frame geometry: 256 samples of packed {re[15:0], im[15:0]}.
  localparam int FFT_N_LOG2 = 8;
  localparam int FFT_DATA_W = 32;

  // Widest index the bit-reverse helper supports.
  localparam int BITREV_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } tx_state_e;

  // Reverse the low 'width' bits of 'value'.
  // The result is right-aligned and the bits above 'width' are zero.
  // A shift loop is used so that no bit is selected by a variable index.
  function automatic logic [BITREV_MAX_W-1:0] bit_reverse(
    input logic [BITREV_MAX_W-1:0] value,
    input int                      width
  );
    logic [BITREV_MAX_W-1:0] src;
    logic [BITREV_MAX_W-1:0] rev;
    src = value;
    rev = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < width) begin
        rev = {rev[BITREV_MAX_W-2:0], src[0]};
        src = src >> 1;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_frame_tx_ram.sv
// Frame buffer for the FFT frame transmitter.
// Simple dual-port RAM with one write port and one read port.
// The read is registered and has a read enable, so the read data stays
// on the output while the consumer is stalled. The structure infers as BRAM.
module fft_frame_ram
  import fft_frame_tx_pkg::*;
#(
  parameter int ADDR_W = FFT_N_LOG2,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port and enabled registered read port.
  // NOTE: there is deliberately no reset on the array or on the read register.
  // A reset would stop the tools from mapping them onto block RAM.
  // Any consumer must qualify o_rd_data with its own valid signal.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      rd_data_q <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_tx.sv
// FFT frame transmitter.
// The loader fills an N-sample buffer. On i_start the frame is streamed
// to the FFT core over valid/ready, in natural or bit-reversed index order.
// The RAM read for sequence index k+1 is issued only on the handshake of
// beat k. The registered RAM output therefore doubles as the output holding
// register: o_data cannot change while a beat is stalled.
module fft_frame_tx
  import fft_frame_tx_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [N_LOG2-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start,
  input  logic              i_bitrev,
  output logic              o_busy,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_last,
  input  logic              i_data_ready,
  output logic              o_frame_done,
  output logic              o_err
);

  localparam logic [N_LOG2-1:0] K_LAST = '1;

  tx_state_e         state_q, state_d;
  logic [N_LOG2-1:0] k_q, k_d;
  logic              bitrev_q, bitrev_d;
  logic              err_q, err_d;

  logic              handshake;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [N_LOG2-1:0] rd_seq;
  logic [N_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  fft_frame_ram #(
    .ADDR_W (N_LOG2),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (ram_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (ram_rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (ram_rd_data)
  );

  assign handshake = (state_q == SEND) && i_data_ready;

  // State register, sequence counter, latched order and error pulse; synchronous reset.
  // NOTE: non-blocking assignments let every register sample the values from
  // before the edge. Blocking assignments here would create ordering races in simulation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      bitrev_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      bitrev_q <= bitrev_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept start, one fetch cycle, stream N beats, one done cycle.
  // NOTE: every signal driven in this block gets a default first.
  // A path that misses an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    bitrev_d = bitrev_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = FETCH;
          k_d      = '0;
          bitrev_d = i_bitrev;
        end
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outside IDLE, a start or a write is dropped and flagged on the next cycle.
    // This includes the DONE cycle.
    err_d = (state_q != IDLE) && (i_start || i_wr_en);
  end

  // RAM control. Writes are accepted only in IDLE.
  // FETCH reads index(0). Each non-final handshake reads index(k+1).
  always_comb begin
    ram_wr_en = i_wr_en && (state_q == IDLE);
    ram_rd_en = (state_q == FETCH) || (handshake && (k_q != K_LAST));
    rd_seq    = (state_q == FETCH) ? '0 : k_q + 1'b1;
    rd_addr   = bitrev_q ? N_LOG2'(bit_reverse(BITREV_MAX_W'(rd_seq), N_LOG2)) : rd_seq;
  end

  // Outputs decoded from state.
  // The read data is masked outside SEND so that o_data is 0 after reset and between frames.
  always_comb begin
    o_busy       = (state_q == FETCH) || (state_q == SEND);
    o_data_valid = (state_q == SEND);
    o_data_last  = (state_q == SEND) && (k_q == K_LAST);
    o_data       = (state_q == SEND) ? ram_rd_data : '0;
    o_frame_done = (state_q == DONE);
    o_err        = err_q;
  end

endmodule

// File: tb/tb_fft_frame_tx.sv
// Self-checking bench for fft_frame_tx.
// A scoreboard queue holds the expected beats of each frame. A frame table
// drives the main cases; hand sequences cover error pulses, reset and
// write-with-start.
module tb_fft_frame_tx;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        bitrev;
  logic        ready;
  logic        busy;
  logic        data_valid;
  logic [31:0] data;
  logic        data_last;
  logic        frame_done;
  logic        err;

  fft_frame_tx dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_start      (start),
    .i_bitrev     (bitrev),
    .o_busy       (busy),
    .o_data_valid (data_valid),
    .o_data       (data),
    .o_data_last  (data_last),
    .i_data_ready (ready),
    .o_frame_done (frame_done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        br;
    logic        rnd;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] b3;
  } frame_vec_t;

  beat_t       exp_q[$];
  logic [31:0] model_mem [N];
  logic [31:0] beat_log  [N];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          hs_total = 0;
  int          err_cnt = 0;
  int          frame_hs = 0;
  int          last_hs_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int rev8(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 8; b++) begin
      if ((k & (1 << b)) != 0) r = r | (1 << (7 - b));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: scoreboard pops on handshake, stall stability, error pulse count
  logic        prev_stall = 1'b0;
  logic        prev_rst   = 1'b1;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  always @(negedge clk) begin
    if (prev_stall && !prev_rst) begin
      check("stall_valid", data_valid, 1);
      check("stall_data", data, prev_data);
      check("stall_last", data_last, prev_last);
    end
    if (data_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got beat 0x%08h, expected no beat", data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("sb_data", data, e.data);
        check("sb_last", data_last, e.last);
      end
      if (frame_hs < N) beat_log[frame_hs] = data;
      frame_hs++;
      hs_total++;
      if (data_last) last_hs_cyc = cyc_cnt;
    end
    if (err) err_cnt++;
    prev_stall = data_valid && !ready;
    prev_data  = data;
    prev_last  = data_last;
    prev_rst   = rst;
  end

  task automatic push_frame(input logic br);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = br ? rev8(k) : k;
      exp_q.push_back('{model_mem[idx], (k == N - 1)});
    end
  endtask

  // mode 0: plain frame
  // mode 1: start at cycle 10 and write at cycle 12 while busy (2 err pulses)
  // mode 2: start during the DONE cycle (1 err pulse, no restart)
  task automatic run_frame(input logic br, input logic rnd, input int mode,
                           input logic ws, input logic [31:0] ws_data);
    int   err0;
    int   hs0;
    int   f_cyc;
    logic got_done;
    err0     = err_cnt;
    hs0      = hs_total;
    frame_hs = 0;
    got_done = 1'b0;
    tick();
    start  = 1'b1;
    bitrev = br;
    if (ws) begin
      wr_en        = 1'b1;
      wr_addr      = 8'd0;
      wr_data      = ws_data;
      model_mem[0] = ws_data;
    end
    push_frame(br);
    tick();
    start  = 1'b0;
    bitrev = 1'b0;
    wr_en  = 1'b0;
    ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    check("lat_busy_t1", busy, 1);
    check("lat_valid_t1", data_valid, 0);
    tick();
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    check("lat_valid_t2", data_valid, 1);
    check("lat_busy_t2", busy, 1);
    f_cyc = cyc_cnt;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      tick();
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1) begin
        if (c == 10) start = 1'b1;
        if (c == 11) start = 1'b0;
        if (c == 12) begin
          wr_en   = 1'b1;
          wr_addr = 8'd5;
          wr_data = 32'hDEADBEEF;
        end
        if (c == 13) wr_en = 1'b0;
      end
      if (mode == 2 && c == 255) start = 1'b1;
      @(negedge clk);
      if (frame_done) got_done = 1'b1;
      else check("busy_in_frame", busy, 1);
    end
    check("done_seen", got_done, 1);
    check("done_busy", busy, 0);
    check("done_valid", data_valid, 0);
    check("done_after_last", cyc_cnt, last_hs_cyc + 1);
    check("hs_count", hs_total - hs0, N);
    check("sb_drained", exp_q.size(), 0);
    if (!rnd) check("burst_cycles", cyc_cnt - f_cyc, N);
    exp_q.delete();
    if (mode != 0) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      repeat (3) @(negedge clk);
      check("no_restart_busy", busy, 0);
      check("no_restart_valid", data_valid, 0);
    end
    check("err_pulses", err_cnt - err0, (mode == 1) ? 2 : ((mode == 2) ? 1 : 0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_last"}, data_last, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  frame_vec_t vecs [4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h00010000, 32'h00020000, 32'h00030000};
    vecs[1] = '{1'b1, 1'b0, 32'h00800000, 32'h00400000, 32'h00C00000};
    vecs[2] = '{1'b0, 1'b1, 32'h00010000, 32'h00020000, 32'h00030000};
    vecs[3] = '{1'b1, 1'b1, 32'h00800000, 32'h00400000, 32'h00C00000};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    bitrev  = 1'b0;
    ready   = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check_outputs_zero("rst");
    tick();
    rst = 1'b0;

    // Load frame: sample i = 0x00010000 * i
    for (int i = 0; i < N; i++) begin
      tick();
      wr_en        = 1'b1;
      wr_addr      = 8'(i);
      wr_data      = 32'(i) << 16;
      model_mem[i] = 32'(i) << 16;
    end
    tick();
    wr_en = 1'b0;

    // Table-driven frames: natural / bit-reversed, ready high / random
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].br, vecs[v].rnd, 0, 1'b0, 32'h0);
      check("vec_beat0", beat_log[0], 32'h00000000);
      check("vec_beat1", beat_log[1], vecs[v].b1);
      check("vec_beat2", beat_log[2], vecs[v].b2);
      check("vec_beat3", beat_log[3], vecs[v].b3);
      check("vec_beat255", beat_log[N-1], 32'h00FF0000);
    end

    // Start and write rejected while busy; entry 5 must be unchanged afterwards
    run_frame(1'b0, 1'b0, 1, 1'b0, 32'h0);
    run_frame(1'b0, 1'b0, 0, 1'b0, 32'h0);
    check("entry5_intact", beat_log[5], 32'h00050000);

    // Start during DONE is rejected
    run_frame(1'b0, 1'b0, 2, 1'b0, 32'h0);

    // Reset at beat 100 drops the frame
    frame_hs = 0;
    tick();
    start = 1'b1;
    push_frame(1'b0);
    tick();
    start = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 1000 && frame_hs < 100; c++) @(negedge clk);
    check("rst_reached_beat100", (frame_hs >= 100), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    check("midrst_idle_busy", busy, 0);
    run_frame(1'b0, 1'b0, 0, 1'b0, 32'h0);
    check("after_rst_beat0", beat_log[0], 32'h00000000);
    check("after_rst_beat100", beat_log[100], 32'h00640000);

    // Write together with start in IDLE is visible to the frame
    run_frame(1'b1, 1'b0, 0, 1'b1, 32'h12345678);
    check("ws_beat0", beat_log[0], 32'h12345678);
    check("ws_beat1", beat_log[1], 32'h00800000);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
